to_udp_ctrl: RTL
================

Name: to_udp_ctrl

Overview:
Control FSM that sequences the to-UDP NoC adapter datapath, which holds the header/metadata/data flit mux and the flit counter. It accepts one metadata request from the app source, then emits a NoC header flit, a UDP TX metadata flit and N payload flits onto the vrtoc NoC port. It drives the datapath's mux-select, init and count strobes, and consumes its last-flit indication. It sits between the app source's val/rdy interfaces and the NoC output val/rdy.

Parameters:
None (flit counting and widths live in the datapath).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
src_to_udp_meta_val  in  1  source metadata valid
udp_to_src_meta_rdy  out  1  metadata accepted when val&rdy
src_to_udp_data_val  in  1  source payload flit valid
udp_to_src_data_rdy  out  1  payload flit accepted when val&rdy
to_udp_noc_vrtoc_val  out  1  NoC flit valid
noc_to_udp_vrtoc_rdy  in  1  NoC ready
ctrl_datap_data_mux_sel  out  to_udp_mux_out_e  HDR_OUT/META_OUT/DATA_OUT
ctrl_datap_init_state  out  1  latch metadata, clear counter, compute total flits
ctrl_datap_cnt_flit  out  1  increment flit counter
datap_ctrl_last_flit  in  1  counter == total_flits-1 (meta+data flits, header excluded)

Behaviour:
- States: READY, HDR, META, DATA. Single registered state; all outputs are combinational from state and inputs.
- Reset (rst==0 at posedge): state<=READY.
  - While rst==0, force to 0: udp_to_src_meta_rdy, udp_to_src_data_rdy, to_udp_noc_vrtoc_val, ctrl_datap_init_state, ctrl_datap_cnt_flit.
  - While rst==0, mux_sel=DATA_OUT.
  - Reset mid-packet aborts immediately. No further flits are emitted. A partial NoC message is not recovered.
- READY:
  - meta_rdy=1.
  - ctrl_datap_init_state = meta_val.
  - On meta_val: -> HDR.
  - data_rdy=0, vrtoc_val=0.
- HDR:
  - mux_sel=HDR_OUT, vrtoc_val=1.
  - On vrtoc_rdy: -> META.
  - No cnt_flit.
- META:
  - mux_sel=META_OUT, vrtoc_val=1.
  - On vrtoc_rdy: cnt_flit=1.
  - Next state: -> READY if last_flit (data_length==0, total_flits==1), else -> DATA.
- DATA:
  - mux_sel=DATA_OUT.
  - vrtoc_val = src_data_val; data_rdy = vrtoc_rdy. These are pure pass-through, with no combinational dependence of rdy on val.
  - cnt_flit = src_data_val & vrtoc_rdy.
  - On that transfer with last_flit: -> READY.
- val must hold stable with its flit until rdy. The FSM never deasserts vrtoc_val in HDR/META without a transfer.
- data_rdy=0 outside DATA. meta_rdy=0 outside READY.
- Throughput:
  - 1 flit/cycle under no backpressure.
  - Packet occupies 2+N NoC cycles.
  - One READY cycle between packets: the earliest next header is 2 cycles after the last data flit.
- last_flit is sampled only in META/DATA on a transfer cycle.
- Illegal state encoding: -> READY.

Optional Feature:
TO_UDP_CTRL_STATS_EN
- Defined: adds outputs stat_pkt_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_pkt_cnt increments on each final-flit transfer (META-last or DATA-last).
  - stat_stall_cnt increments each cycle with vrtoc_val=1 and vrtoc_rdy=0.
  - Both are cleared on reset and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- to_udp_mux_out_e (HDR_OUT, META_OUT, DATA_OUT) stays in app_udp_adapter_pkg, shared with the datapath.
- FSM state enum is local to to_udp_ctrl.
- No sub-module. The enclosing adapter instantiates to_udp_ctrl alongside the datapath and wires the ctrl_datap_*/datap_ctrl_* signals.

Test Plan:
- NOC_DATA_W=256, data_length=0, rdy always 1 -> exactly 2 NoC flits (HDR, META), msg_len=1, one cnt_flit pulse, back in READY on cycle 3.
- data_length=64 -> HDR, META, 2 DATA flits; cnt_flit pulses=3; data_rdy high only in the 2 DATA cycles.
- data_length=65 -> 3 DATA flits, msg_len=4; last_flit consumed on the 3rd data transfer, FSM returns to READY.
- NoC rdy toggled 1010… during HDR/META/DATA -> flit order preserved, vrtoc_val/mux_sel stable across stalls. With STATS_EN, stat_stall_cnt equals the number of stalled cycles.
- Two back-to-back meta requests (length 32 each) -> second meta_rdy handshake occurs in the cycle after the first packet's last flit; NoC sees 6 flits with one idle cycle between packets.
- rst=0 asserted during DATA of a 96-byte packet -> next cycle all val/rdy outputs 0, state READY. A subsequent length-32 request is sent correctly (3 flits).

Source files
------------

// File: rtl/app_udp_adapter_pkg.sv
// -----------------------------------------------------------------------------
// app_udp_adapter_pkg
// Definitions shared by the to-UDP NoC adapter control FSM and its datapath.
//   to_udp_mux_out_e : selects which flit the datapath places on the NoC port
//                      (NoC header, UDP TX metadata, or app payload).
// -----------------------------------------------------------------------------
package app_udp_adapter_pkg;

   typedef enum logic [1:0] {
      HDR_OUT  = 2'd0,
      META_OUT = 2'd1,
      DATA_OUT = 2'd2
   } to_udp_mux_out_e;

endpackage : app_udp_adapter_pkg

// File: rtl/to_udp_ctrl.sv
// -----------------------------------------------------------------------------
// to_udp_ctrl
// Control FSM for the to-UDP NoC adapter. It accepts one metadata request from
// the app source. It then sequences a NoC header flit, a UDP TX metadata flit
// and the payload flits onto the vrtoc NoC port. It does this by steering the
// datapath flit mux and pulsing the datapath init/count strobes.
//
// Ports
//   clk                      clock
//   rst                      synchronous reset, active-low
//   src_to_udp_meta_val      source metadata valid
//   udp_to_src_meta_rdy      metadata ready (READY state only)
//   src_to_udp_data_val      source payload flit valid
//   udp_to_src_data_rdy      payload ready (DATA state only, = NoC rdy)
//   to_udp_noc_vrtoc_val     NoC flit valid
//   noc_to_udp_vrtoc_rdy     NoC ready
//   ctrl_datap_data_mux_sel  datapath flit select (HDR_OUT/META_OUT/DATA_OUT)
//   ctrl_datap_init_state    latch metadata, clear flit counter
//   ctrl_datap_cnt_flit      advance flit counter (one per meta/data transfer)
//   datap_ctrl_last_flit     current meta/data flit is the final one
//
// Optional build macro TO_UDP_CTRL_STATS_EN adds:
//   stat_pkt_cnt[31:0]       completed packets (final-flit transfers)
//   stat_stall_cnt[31:0]     cycles with vrtoc_val=1 and vrtoc_rdy=0
// -----------------------------------------------------------------------------
module to_udp_ctrl
   import app_udp_adapter_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            src_to_udp_meta_val,
   output logic            udp_to_src_meta_rdy,
   input  logic            src_to_udp_data_val,
   output logic            udp_to_src_data_rdy,
   output logic            to_udp_noc_vrtoc_val,
   input  logic            noc_to_udp_vrtoc_rdy,
   output to_udp_mux_out_e ctrl_datap_data_mux_sel,
   output logic            ctrl_datap_init_state,
   output logic            ctrl_datap_cnt_flit,
   input  logic            datap_ctrl_last_flit
`ifdef TO_UDP_CTRL_STATS_EN
   ,
   output logic [31:0]     stat_pkt_cnt,
   output logic [31:0]     stat_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_HDR   = 2'd1,
      ST_META  = 2'd2,
      ST_DATA  = 2'd3
   } state_e;

   state_e r_state;
   state_e w_next_state;

   // State register; reset returns to READY and abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_READY;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; last_flit only matters on a META/DATA transfer.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_READY: begin
            if (src_to_udp_meta_val) begin
               w_next_state = ST_HDR;
            end else begin
               w_next_state = ST_READY;
            end
         end
         ST_HDR: begin
            if (noc_to_udp_vrtoc_rdy) begin
               w_next_state = ST_META;
            end else begin
               w_next_state = ST_HDR;
            end
         end
         ST_META: begin
            // A zero-length payload makes the metadata flit the final one.
            if (noc_to_udp_vrtoc_rdy && datap_ctrl_last_flit) begin
               w_next_state = ST_READY;
            end else if (noc_to_udp_vrtoc_rdy) begin
               w_next_state = ST_DATA;
            end else begin
               w_next_state = ST_META;
            end
         end
         ST_DATA: begin
            if (src_to_udp_data_val && noc_to_udp_vrtoc_rdy && datap_ctrl_last_flit) begin
               w_next_state = ST_READY;
            end else begin
               w_next_state = ST_DATA;
            end
         end
         default: begin
            w_next_state = ST_READY;
         end
      endcase
   end

   // Output decode; reset forces every handshake and strobe low at once.
   always_comb begin
      udp_to_src_meta_rdy     = 1'b0;
      udp_to_src_data_rdy     = 1'b0;
      to_udp_noc_vrtoc_val    = 1'b0;
      ctrl_datap_data_mux_sel = DATA_OUT;
      ctrl_datap_init_state   = 1'b0;
      ctrl_datap_cnt_flit     = 1'b0;
      if (rst) begin
         case (r_state)
            ST_READY: begin
               udp_to_src_meta_rdy   = 1'b1;
               ctrl_datap_init_state = src_to_udp_meta_val;
            end
            ST_HDR: begin
               ctrl_datap_data_mux_sel = HDR_OUT;
               to_udp_noc_vrtoc_val    = 1'b1;
            end
            ST_META: begin
               ctrl_datap_data_mux_sel = META_OUT;
               to_udp_noc_vrtoc_val    = 1'b1;
               ctrl_datap_cnt_flit     = noc_to_udp_vrtoc_rdy;
            end
            ST_DATA: begin
               // Payload val/rdy pass straight through; rdy never looks at val.
               ctrl_datap_data_mux_sel = DATA_OUT;
               to_udp_noc_vrtoc_val    = src_to_udp_data_val;
               udp_to_src_data_rdy     = noc_to_udp_vrtoc_rdy;
               ctrl_datap_cnt_flit     = src_to_udp_data_val & noc_to_udp_vrtoc_rdy;
            end
            default: begin
               ctrl_datap_data_mux_sel = DATA_OUT;
            end
         endcase
      end else begin
         udp_to_src_meta_rdy     = 1'b0;
         udp_to_src_data_rdy     = 1'b0;
         to_udp_noc_vrtoc_val    = 1'b0;
         ctrl_datap_data_mux_sel = DATA_OUT;
         ctrl_datap_init_state   = 1'b0;
         ctrl_datap_cnt_flit     = 1'b0;
      end
   end

`ifdef TO_UDP_CTRL_STATS_EN
   logic        w_final_xfer;
   logic        w_stall;
   logic [31:0] r_stat_pkt_cnt;
   logic [31:0] r_stat_stall_cnt;

   // cnt_flit fires only on META/DATA transfers, so together with last_flit it
   // marks the final flit of a packet.
   assign w_final_xfer = ctrl_datap_cnt_flit & datap_ctrl_last_flit;
   assign w_stall      = to_udp_noc_vrtoc_val & ~noc_to_udp_vrtoc_rdy;

   // Free-running statistics counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stat_pkt_cnt   <= 32'd0;
         r_stat_stall_cnt <= 32'd0;
      end else begin
         r_stat_pkt_cnt   <= r_stat_pkt_cnt + {31'd0, w_final_xfer};
         r_stat_stall_cnt <= r_stat_stall_cnt + {31'd0, w_stall};
      end
   end

   assign stat_pkt_cnt   = r_stat_pkt_cnt;
   assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule : to_udp_ctrl
